bsg_manycore_link_retimer: RTL and testbench

//  Registered, fully elastic retiming stage placed on one mesh edge between two adjacent

---
 rtl/bsg_manycore_link_retimer_pkg.sv | 21 ++
 rtl/bsg_manycore_link_retimer_lane.sv | 73 +++++++
 rtl/bsg_manycore_link_retimer.sv | 97 +++++++++
 tb/tb_bsg_manycore_link_retimer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_link_retimer_pkg.sv
// rtl/bsg_manycore_link_retimer_pkg.sv - lane enum and link_sif layout helpers for the mesh-edge retimer
package bsg_manycore_link_retimer_pkg;

  typedef enum logic [1:0] {e_fwd_ab, e_fwd_ba, e_rev_ab, e_rev_ba} lane_e;

  // Forward packet: addr, data, src/dst coordinates, op and mask bits
  function automatic int fwd_pkt_width(input int addr_w, input int data_w, input int x_w, input int y_w);
    return addr_w + data_w + 2 * (x_w + y_w) + 4;
  endfunction

  // Return packet: data, destination coordinates, type and register id
  function automatic int ret_pkt_width(input int data_w, input int x_w, input int y_w);
    return data_w + x_w + y_w + 5;
  endfunction

  // link_sif = {fwd.v, fwd.ready_and_rev, fwd.data, rev.v, rev.ready_and_rev, rev.data}
  function automatic int link_sif_width(input int addr_w, input int data_w, input int x_w, input int y_w);
    return 4 + fwd_pkt_width(addr_w, data_w, x_w, y_w) + ret_pkt_width(data_w, x_w, y_w);
  endfunction

endpackage

// File: rtl/bsg_manycore_link_retimer_lane.sv
// rtl/bsg_manycore_link_retimer_lane.sv - 2-entry elastic buffer with saturating stall counter
module bsg_manycore_link_retimer_lane
  #(parameter int width_p           = 8,
    parameter int stall_cnt_width_p = 16)
  (input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         v_i,
   input  logic [width_p-1:0]           data_i,
   output logic                         ready_o,
   output logic                         v_o,
   output logic [width_p-1:0]           data_o,
   input  logic                         ready_i,
   input  logic                         stall_clear_i,
   output logic [stall_cnt_width_p-1:0] stall_cnt_o);

  logic [1:0]                   count_q, count_d;
  logic                         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                         v_q, v_d, ready_q, ready_d;
  logic [1:0][width_p-1:0]      mem_q, mem_d;
  logic [stall_cnt_width_p-1:0] stall_q, stall_d;
  logic                         enq, deq;

  always_comb begin
    enq      = v_i & ready_q;
    deq      = v_q & ready_i;
    count_d  = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    wr_ptr_d = wr_ptr_q ^ enq;
    rd_ptr_d = rd_ptr_q ^ deq;
    mem_d    = mem_q;
    if (enq) mem_d[wr_ptr_q] = data_i;
    // Handshake outputs are flopped copies of the next occupancy, so no input reaches them combinationally
    v_d      = (count_d != 2'd0);
    ready_d  = (count_d != 2'd2);
    stall_d  = stall_q;
    if (stall_clear_i)
      stall_d = '0;
    else if (v_q & ~ready_i & ~(&stall_q))
      stall_d = stall_q + stall_cnt_width_p'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      v_q      <= 1'b0;
      ready_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      v_q      <= v_d;
      ready_q  <= ready_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign ready_o     = ready_q;
  assign v_o         = v_q;
  assign data_o      = mem_q[rd_ptr_q];
  assign stall_cnt_o = stall_q;

endmodule

// File: rtl/bsg_manycore_link_retimer.sv
// rtl/bsg_manycore_link_retimer.sv - fully registered retiming stage for one mesh edge (fwd, rev, barrier)
module bsg_manycore_link_retimer
  import bsg_manycore_link_retimer_pkg::*;
  #(parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int stall_cnt_width_p = 16,
    localparam int fwd_w_lp          = fwd_pkt_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int ret_w_lp          = ret_pkt_width(data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int link_sif_width_lp = link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p))
  (input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [link_sif_width_lp-1:0]   a_link_i,
   output logic [link_sif_width_lp-1:0]   a_link_o,
   input  logic [link_sif_width_lp-1:0]   b_link_i,
   output logic [link_sif_width_lp-1:0]   b_link_o,
   input  logic                           a_barrier_i,
   output logic                           a_barrier_o,
   input  logic                           b_barrier_i,
   output logic                           b_barrier_o,
   input  logic                           stall_clear_i,
   output logic [4*stall_cnt_width_p-1:0] stall_cnt_o);

  localparam int rev_rdy_lp      = ret_w_lp;
  localparam int rev_v_lp        = ret_w_lp + 1;
  localparam int fwd_data_lsb_lp = ret_w_lp + 2;
  localparam int fwd_rdy_lp      = ret_w_lp + 2 + fwd_w_lp;
  localparam int fwd_v_lp        = ret_w_lp + 3 + fwd_w_lp;

  logic [3:0]                         v_in, ready_in, v_out, ready_out;
  logic [3:0][stall_cnt_width_p-1:0]  stall_cnt;
  logic [fwd_w_lp-1:0]                fwd_ab_data, fwd_ba_data;
  logic [ret_w_lp-1:0]                rev_ab_data, rev_ba_data;
  logic                               a_barrier_q, a_barrier_d, b_barrier_q, b_barrier_d;

  // A lane's ready comes from the receiving side's link_i ready_and_rev of the same network
  assign v_in[e_fwd_ab]     = a_link_i[fwd_v_lp];
  assign v_in[e_fwd_ba]     = b_link_i[fwd_v_lp];
  assign v_in[e_rev_ab]     = a_link_i[rev_v_lp];
  assign v_in[e_rev_ba]     = b_link_i[rev_v_lp];
  assign ready_in[e_fwd_ab] = b_link_i[fwd_rdy_lp];
  assign ready_in[e_fwd_ba] = a_link_i[fwd_rdy_lp];
  assign ready_in[e_rev_ab] = b_link_i[rev_rdy_lp];
  assign ready_in[e_rev_ba] = a_link_i[rev_rdy_lp];

  bsg_manycore_link_retimer_lane #(.width_p(fwd_w_lp), .stall_cnt_width_p(stall_cnt_width_p)) fwd_ab_lane
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_in[e_fwd_ab]),
     .data_i(a_link_i[fwd_data_lsb_lp +: fwd_w_lp]), .ready_o(ready_out[e_fwd_ab]),
     .v_o(v_out[e_fwd_ab]), .data_o(fwd_ab_data), .ready_i(ready_in[e_fwd_ab]),
     .stall_clear_i(stall_clear_i), .stall_cnt_o(stall_cnt[e_fwd_ab]));

  bsg_manycore_link_retimer_lane #(.width_p(fwd_w_lp), .stall_cnt_width_p(stall_cnt_width_p)) fwd_ba_lane
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_in[e_fwd_ba]),
     .data_i(b_link_i[fwd_data_lsb_lp +: fwd_w_lp]), .ready_o(ready_out[e_fwd_ba]),
     .v_o(v_out[e_fwd_ba]), .data_o(fwd_ba_data), .ready_i(ready_in[e_fwd_ba]),
     .stall_clear_i(stall_clear_i), .stall_cnt_o(stall_cnt[e_fwd_ba]));

  bsg_manycore_link_retimer_lane #(.width_p(ret_w_lp), .stall_cnt_width_p(stall_cnt_width_p)) rev_ab_lane
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_in[e_rev_ab]),
     .data_i(a_link_i[ret_w_lp-1:0]), .ready_o(ready_out[e_rev_ab]),
     .v_o(v_out[e_rev_ab]), .data_o(rev_ab_data), .ready_i(ready_in[e_rev_ab]),
     .stall_clear_i(stall_clear_i), .stall_cnt_o(stall_cnt[e_rev_ab]));

  bsg_manycore_link_retimer_lane #(.width_p(ret_w_lp), .stall_cnt_width_p(stall_cnt_width_p)) rev_ba_lane
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_in[e_rev_ba]),
     .data_i(b_link_i[ret_w_lp-1:0]), .ready_o(ready_out[e_rev_ba]),
     .v_o(v_out[e_rev_ba]), .data_o(rev_ba_data), .ready_i(ready_in[e_rev_ba]),
     .stall_clear_i(stall_clear_i), .stall_cnt_o(stall_cnt[e_rev_ba]));

  assign a_link_o = {v_out[e_fwd_ba], ready_out[e_fwd_ab], fwd_ba_data,
                     v_out[e_rev_ba], ready_out[e_rev_ab], rev_ba_data};
  assign b_link_o = {v_out[e_fwd_ab], ready_out[e_fwd_ba], fwd_ab_data,
                     v_out[e_rev_ab], ready_out[e_rev_ba], rev_ab_data};

  // Enum order places rev_ba in the top slice, matching {rev_ba,rev_ab,fwd_ba,fwd_ab}
  assign stall_cnt_o = stall_cnt;

  always_comb begin
    a_barrier_d = b_barrier_i;
    b_barrier_d = a_barrier_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_barrier_q <= 1'b0;
      b_barrier_q <= 1'b0;
    end else begin
      a_barrier_q <= a_barrier_d;
      b_barrier_q <= b_barrier_d;
    end
  end

  assign a_barrier_o = a_barrier_q;
  assign b_barrier_o = b_barrier_q;

endmodule

// File: tb/tb_bsg_manycore_link_retimer.sv
// tb/tb_bsg_manycore_link_retimer.sv - directed scoreboard bench for bsg_manycore_link_retimer
module tb_bsg_manycore_link_retimer;

  localparam int FWD_W = 28;
  localparam int RET_W = 17;
  localparam int LW    = 4 + FWD_W + RET_W;
  localparam int SW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [LW-1:0] a_link_i, a_link_o, b_link_i, b_link_o;
  logic a_barrier_i, a_barrier_o, b_barrier_i, b_barrier_o;
  logic stall_clear;
  logic [4*SW-1:0] stall_cnt;

  logic a_fwd_v, a_fwd_rdy, a_rev_v, a_rev_rdy;
  logic b_fwd_v, b_fwd_rdy, b_rev_v, b_rev_rdy;
  logic [FWD_W-1:0] a_fwd_data, b_fwd_data;
  logic [RET_W-1:0] a_rev_data, b_rev_data;

  logic ao_fwd_v, ao_fwd_rdy, ao_rev_v, ao_rev_rdy;
  logic bo_fwd_v, bo_fwd_rdy, bo_rev_v, bo_rev_rdy;
  logic [FWD_W-1:0] ao_fwd_data, bo_fwd_data;
  logic [RET_W-1:0] ao_rev_data, bo_rev_data;

  int checks = 0;
  int failures = 0;
  int popped = 0;
  logic [FWD_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  assign a_link_i = {a_fwd_v, a_fwd_rdy, a_fwd_data, a_rev_v, a_rev_rdy, a_rev_data};
  assign b_link_i = {b_fwd_v, b_fwd_rdy, b_fwd_data, b_rev_v, b_rev_rdy, b_rev_data};
  assign {ao_fwd_v, ao_fwd_rdy, ao_fwd_data, ao_rev_v, ao_rev_rdy, ao_rev_data} = a_link_o;
  assign {bo_fwd_v, bo_fwd_rdy, bo_fwd_data, bo_rev_v, bo_rev_rdy, bo_rev_data} = b_link_o;

  bsg_manycore_link_retimer #(
    .addr_width_p(8), .data_width_p(8), .x_cord_width_p(2), .y_cord_width_p(2),
    .stall_cnt_width_p(SW)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .a_link_i(a_link_i), .a_link_o(a_link_o),
    .b_link_i(b_link_i), .b_link_o(b_link_o),
    .a_barrier_i(a_barrier_i), .a_barrier_o(a_barrier_o),
    .b_barrier_i(b_barrier_i), .b_barrier_o(b_barrier_o),
    .stall_clear_i(stall_clear), .stall_cnt_o(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the fwd A->B lane: push on accept, pop on delivery
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (bo_fwd_v && b_fwd_rdy) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 64'(bo_fwd_data), 64'hdead);
        end else begin
          check("sb_data", 64'(bo_fwd_data), 64'(sb_q.pop_front()));
          popped++;
        end
      end
      if (a_fwd_v && ao_fwd_rdy) sb_q.push_back(a_fwd_data);
    end
  end

  initial begin
    int p0;
    bit ok;
    rst_n = 1'b0;
    a_fwd_v = 1'b1; b_fwd_v = 1'b1; a_rev_v = 1'b1; b_rev_v = 1'b1;
    a_fwd_rdy = 1'b1; b_fwd_rdy = 1'b1; a_rev_rdy = 1'b1; b_rev_rdy = 1'b1;
    a_fwd_data = '0; b_fwd_data = '0; a_rev_data = '0; b_rev_data = '0;
    a_barrier_i = 1'b0; b_barrier_i = 1'b0; stall_clear = 1'b0;

    // Reset held 3 cycles with valid asserted
    repeat (3) step();
    check("rst_v", {ao_fwd_v, ao_rev_v, bo_fwd_v, bo_rev_v}, 4'h0);
    check("rst_rdy", {ao_fwd_rdy, ao_rev_rdy, bo_fwd_rdy, bo_rev_rdy}, 4'h0);
    check("rst_stall", stall_cnt, 0);
    check("rst_barrier", {a_barrier_o, b_barrier_o}, 2'b00);
    a_fwd_v = 1'b0; b_fwd_v = 1'b0; a_rev_v = 1'b0; b_rev_v = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", {ao_fwd_rdy, ao_rev_rdy, bo_fwd_rdy, bo_rev_rdy}, 4'h0);
    step();
    check("rdy_after_edge", {ao_fwd_rdy, ao_rev_rdy, bo_fwd_rdy, bo_rev_rdy}, 4'hf);

    // Other three lanes, one packet each
    b_fwd_v = 1'b1; b_fwd_data = 28'h123;
    b_rev_v = 1'b1; b_rev_data = 17'h55;
    a_rev_v = 1'b1; a_rev_data = 17'h66;
    step();
    b_fwd_v = 1'b0; b_rev_v = 1'b0; a_rev_v = 1'b0;
    check("fwd_ba", {ao_fwd_v, 32'(ao_fwd_data)}, {1'b1, 32'h123});
    check("rev_ba", {ao_rev_v, 32'(ao_rev_data)}, {1'b1, 32'h55});
    check("rev_ab", {bo_rev_v, 32'(bo_rev_data)}, {1'b1, 32'h66});
    step();
    check("others_drained", {ao_fwd_v, ao_rev_v, bo_rev_v}, 3'b000);

    // Streaming 100 back-to-back packets
    p0 = popped;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a_fwd_v = 1'b1; a_fwd_data = FWD_W'(i);
      step();
      if (i == 0) check("first_latency", {bo_fwd_v, 32'(bo_fwd_data)}, {1'b1, 32'h0});
      ok &= ao_fwd_rdy & bo_fwd_v;
    end
    a_fwd_v = 1'b0;
    check("stream_rdy_v_high", ok, 1'b1);
    step(); step();
    check("stream_count", popped - p0, 100);
    check("stream_drained", bo_fwd_v, 1'b0);

    // Backpressure: five stalled cycles
    stall_clear = 1'b1; step(); stall_clear = 1'b0;
    check("clear_stall", stall_cnt, 0);
    b_fwd_rdy = 1'b0;
    a_fwd_v = 1'b1; a_fwd_data = 28'hA; step();
    a_fwd_data = 28'hB; step();
    a_fwd_data = 28'hC; step();
    check("full_rdy_low", ao_fwd_rdy, 1'b0);
    check("full_head", 64'(bo_fwd_data), 64'hA);
    step(); step(); step();
    check("stall_5", stall_cnt[SW-1:0], 5);
    b_fwd_rdy = 1'b1; step();
    check("rdy_reopen", ao_fwd_rdy, 1'b1);
    step();
    a_fwd_v = 1'b0;
    step(); step();
    check("stall_hold", stall_cnt[SW-1:0], 5);
    check("bp_drained", bo_fwd_v, 1'b0);

    // Simultaneous enq/deq at count 1
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_fwd_v = 1'b1; a_fwd_data = FWD_W'(32'h100 + i);
      step();
      ok &= ao_fwd_rdy & bo_fwd_v;
    end
    a_fwd_v = 1'b0;
    check("simul_flow", ok, 1'b1);
    step(); step();

    // Full/empty alternation to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      b_fwd_rdy = 1'b0;
      a_fwd_v = 1'b1; a_fwd_data = FWD_W'(32'h200 + 2 * r); step();
      a_fwd_data = FWD_W'(32'h201 + 2 * r); step();
      a_fwd_v = 1'b0;
      check("wrap_full", ao_fwd_rdy, 1'b0);
      b_fwd_rdy = 1'b1; step(); step();
      check("wrap_empty", bo_fwd_v, 1'b0);
    end

    // Saturation at 15 and clear priority
    stall_clear = 1'b1; step(); stall_clear = 1'b0;
    b_fwd_rdy = 1'b0;
    a_fwd_v = 1'b1; a_fwd_data = 28'h300; step();
    a_fwd_v = 1'b0;
    repeat (20) step();
    check("stall_sat", stall_cnt[SW-1:0], 15);
    stall_clear = 1'b1; step();
    check("stall_clear_prio", stall_cnt[SW-1:0], 0);
    stall_clear = 1'b0; step();
    check("stall_resume", stall_cnt[SW-1:0], 1);
    b_fwd_rdy = 1'b1; step(); step();
    check("sat_drained", bo_fwd_v, 1'b0);

    // Barrier delay
    a_barrier_i = 1'b1;
    #1;
    check("barrier_not_yet", b_barrier_o, 1'b0);
    step();
    check("barrier_ab_1", {b_barrier_o, a_barrier_o}, 2'b10);
    a_barrier_i = 1'b0; b_barrier_i = 1'b1;
    step();
    check("barrier_ab_0", {b_barrier_o, a_barrier_o}, 2'b01);

    // Reset with two packets buffered
    b_fwd_rdy = 1'b0;
    a_fwd_v = 1'b1; a_fwd_data = 28'h3A; step();
    a_fwd_data = 28'h3B; step();
    a_fwd_v = 1'b0;
    check("pre_reset_v", bo_fwd_v, 1'b1);
    p0 = popped;
    rst_n = 1'b0;
    #1;
    check("reset_async_v", {bo_fwd_v, ao_fwd_rdy}, 2'b00);
    check("reset_async_misc", {32'(stall_cnt), a_barrier_o}, 33'd0);
    b_fwd_rdy = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    check("post_reset_no_pkt", bo_fwd_v, 1'b0);
    check("post_reset_popped", popped - p0, 0);
    check("sb_final_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
